instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Front-end fetch stage. It issues one word read per cycle to a synchronous
//   instruction memory (data returns the cycle after the request). Responses
//   are captured into an IF/ID output register (if_*). A one-entry skid
//   register absorbs the single response that can still be in flight when
//   decode stalls. Redirects from later stages squash everything buffered and
//   in flight, and take priority over every other event.
//
// Optional feature (compile-time macro IFETCH_MISALIGN_CHECK_EN):
//   defined   -> a redirect whose target has nonzero low bits sets the sticky
//                misalign_o flag and halts fetch until reset.
//   undefined -> misalign_o does not exist; redirect_pc_i[1:0] is forced to 0.
//
// Ports:
//   clk_i            in   clock, all state on posedge
//   reset_i          in   asynchronous active-high reset
//   mem_rd_valid_o   out  read request (combinational)
//   mem_rd_addr_o    out  word address = fetch_pc[AddrWidth+1:2]
//   mem_rd_data_i    in   read data, valid the cycle after the request
//   redirect_i       in   branch/jump redirect
//   redirect_pc_i    in   redirect target byte PC
//   if_valid_o       out  IF/ID register holds an instruction
//   if_ready_i       in   decode accepts the instruction this cycle
//   if_pc_o          out  byte PC of if_instr_o
//   if_instr_o       out  fetched instruction
//   misalign_o       out  sticky misaligned-redirect flag (macro builds only)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned NumEntries = 31,
  parameter logic [31:0] ResetPc    = 32'h0,
  localparam int unsigned AddrWidth = $clog2(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  output logic                 mem_rd_valid_o,
  output logic [AddrWidth-1:0] mem_rd_addr_o,
  input  logic [DataWidth-1:0] mem_rd_data_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  output logic                 if_valid_o,
  input  logic                 if_ready_i,
  output logic [31:0]          if_pc_o,
  output logic [DataWidth-1:0] if_instr_o
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic                 misalign_o
`endif
);

  localparam logic [DataWidth-1:0] NopInstr = DataWidth'(32'h0000_0013);

  logic [31:0]          fetch_pc_q,   fetch_pc_d;
  logic                 req_live_q,   req_live_d;
  logic [31:0]          req_pc_q,     req_pc_d;
  logic                 if_valid_q,   if_valid_d;
  logic [31:0]          if_pc_q,      if_pc_d;
  logic [DataWidth-1:0] if_instr_q,   if_instr_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [31:0]          skid_pc_q,    skid_pc_d;
  logic [DataWidth-1:0] skid_instr_q, skid_instr_d;

  logic [31:0] redirect_target;
  logic        fetch_halt;
  logic        out_xfer;
  logic        out_load;
  logic        mem_req;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign fetch_halt      = misalign_q;
  assign misalign_o      = misalign_q;
`else
  logic unused_redirect_lsbs;

  // Low target bits are dropped: every fetch is word aligned.
  assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
  assign fetch_halt           = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
`endif

  assign out_xfer = if_valid_q & if_ready_i;
  assign out_load = ~if_valid_q | out_xfer;

  // A request is only safe when its response is guaranteed a home next cycle:
  // the skid must be empty, and we must not already have a response landing
  // into a stalled, full output register (that one takes the skid).
  assign mem_req = ~reset_i & ~redirect_i & ~skid_valid_q & ~fetch_halt &
                   ~(req_live_q & if_valid_q & ~if_ready_i);

  assign mem_rd_valid_o = mem_req;
  assign mem_rd_addr_o  = fetch_pc_q[AddrWidth+1:2];

  assign if_valid_o = if_valid_q;
  assign if_pc_o    = if_pc_q;
  assign if_instr_o = if_instr_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    req_live_d   = mem_req;
    req_pc_d     = fetch_pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
    misalign_d   = misalign_q;
`endif

    if (redirect_i) begin
      // Redirect wins: drop output, skid and the response arriving now.
      fetch_pc_d   = redirect_target;
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
`endif
    end else begin
      if (mem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (out_load) begin
        if (skid_valid_q) begin
          // Older skid entry goes first; the live response (if any) refills it.
          if_valid_d   = 1'b1;
          if_pc_d      = skid_pc_q;
          if_instr_d   = skid_instr_q;
          skid_valid_d = req_live_q;
          if (req_live_q) begin
            skid_pc_d    = req_pc_q;
            skid_instr_d = mem_rd_data_i;
          end
        end else if (req_live_q) begin
          if_valid_d = 1'b1;
          if_pc_d    = req_pc_q;
          if_instr_d = mem_rd_data_i;
        end else begin
          if_valid_d = 1'b0;
        end
      end else if (req_live_q) begin
        // Output stalled and full: the in-flight response parks in the skid,
        // which the request gating guarantees is empty here.
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = mem_rd_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q   <= ResetPc;
      req_live_q   <= 1'b0;
      req_pc_q     <= ResetPc;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'h0;
      if_instr_q   <= NopInstr;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NopInstr;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      req_live_q   <= req_live_d;
      req_pc_q     <= req_pc_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

endmodule
